pipelined_controller: RTL

PIPELINED_CONTROLLER -- requirements
Module: pipelined_controller

---
 rtl/pipelined_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_controller.sv
// pipelined_controller: ID decode plus ID/EX, EX/MEM, MEM/WB control pipeline
// with load-use stall, branch/jump flush and illegal-opcode pulse. Rev 1.0
`default_nettype none

module pipelined_controller #(
  parameter int INSTR_W = 32,
  parameter int ALUF_W  = 4,
  parameter int REG_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic               branch_condition,
  output logic               ex_alusrc,
  output logic [ALUF_W-1:0]  ex_alufunc,
  output logic               ex_regdest,
  output logic               mem_readdmem,
  output logic               mem_writedmem,
  output logic               wb_regwrite,
  output logic               wb_memtoreg,
  output logic               pcsrc,
  output logic               stall,
  output logic               flush,
  output logic               illegal
);

  typedef struct packed {
    logic              alusrc;
    logic [ALUF_W-1:0] alufunc;
    logic              regdest;
    logic              readdmem;
    logic              writedmem;
    logic              regwrite;
    logic              memtoreg;
    logic              branch;
    logic              jump;
  } ctrl_t;

  localparam logic [5:0] OP_MOVE = 6'b011010;
  localparam logic [5:0] OP_LD   = 6'b100001;
  localparam logic [5:0] OP_ST   = 6'b100010;
  localparam logic [5:0] OP_BR   = 6'b110100;

  logic [1:0]       cls;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  ctrl_t            dec;
  logic             dec_illegal;
  logic             uses_rt;
  logic             hazard;
  logic             unused_instr;

  ctrl_t            id_ex;
  logic [REG_W-1:0] id_ex_rt;
  logic             ex_mem_readdmem;
  logic             ex_mem_writedmem;
  logic             ex_mem_regwrite;
  logic             ex_mem_memtoreg;
  logic             mem_wb_regwrite;
  logic             mem_wb_memtoreg;
  logic             illegal_q;

  assign cls          = instr[31:30];
  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign rs           = REG_W'(instr[25:21]);
  assign rt           = REG_W'(instr[20:16]);
  assign unused_instr = ^instr;

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    case (cls)
      2'b00: begin
        if (funct >= 6'd1 && funct <= 6'd10) begin
          dec.alufunc  = ALUF_W'(funct - 6'd1);
          dec.regdest  = 1'b1;
          dec.regwrite = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      2'b01: begin
        if (opcode <= 6'b011001 || opcode == OP_MOVE) begin
          // MOVE maps to function 0; the arithmetic range maps linearly
          dec.alufunc  = (opcode == OP_MOVE) ? '0 : ALUF_W'(opcode - 6'b010000);
          dec.alusrc   = 1'b1;
          dec.regwrite = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      2'b10: begin
        if (opcode == OP_LD) begin
          dec.alusrc   = 1'b1;
          dec.readdmem = 1'b1;
          dec.regwrite = 1'b1;
          dec.memtoreg = 1'b1;
        end else if (opcode == OP_ST) begin
          dec.alusrc    = 1'b1;
          dec.writedmem = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: begin
        if (opcode <= 6'b110011) begin
          dec.branch = 1'b1;
        end else if (opcode == OP_BR) begin
          dec.jump = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
    endcase
    if (!instr_valid || dec_illegal) begin
      dec = '0;
    end
  end

  assign pcsrc   = id_ex.jump | (id_ex.branch & branch_condition);
  assign flush   = pcsrc;
  assign uses_rt = (cls == 2'b00) || (opcode == OP_ST);
  assign hazard  = instr_valid && id_ex.readdmem &&
                   ((id_ex_rt == rs) || (uses_rt && (id_ex_rt == rt)));
  assign stall   = hazard && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex            <= '0;
      id_ex_rt         <= '0;
      ex_mem_readdmem  <= 1'b0;
      ex_mem_writedmem <= 1'b0;
      ex_mem_regwrite  <= 1'b0;
      ex_mem_memtoreg  <= 1'b0;
      mem_wb_regwrite  <= 1'b0;
      mem_wb_memtoreg  <= 1'b0;
      illegal_q        <= 1'b0;
    end else begin
      id_ex            <= (flush || stall) ? '0 : dec;
      id_ex_rt         <= rt;
      ex_mem_readdmem  <= id_ex.readdmem;
      ex_mem_writedmem <= id_ex.writedmem;
      ex_mem_regwrite  <= id_ex.regwrite;
      ex_mem_memtoreg  <= id_ex.memtoreg;
      mem_wb_regwrite  <= ex_mem_regwrite;
      mem_wb_memtoreg  <= ex_mem_memtoreg;
      illegal_q        <= instr_valid && dec_illegal && !stall && !flush;
    end
  end

  assign ex_alusrc     = id_ex.alusrc;
  assign ex_alufunc    = id_ex.alufunc;
  assign ex_regdest    = id_ex.regdest;
  assign mem_readdmem  = ex_mem_readdmem;
  assign mem_writedmem = ex_mem_writedmem;
  assign wb_regwrite   = mem_wb_regwrite;
  assign wb_memtoreg   = mem_wb_memtoreg;
  assign illegal       = illegal_q;

endmodule

`default_nettype wire
